// File: rtl/tinyriscv_pkg.sv
// Shared CSR definitions for the tinyriscv machine-mode CSR file.
package tinyriscv_pkg;

  typedef enum logic [1:0] {
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  // Machine trap setup / handling
  localparam logic [11:0] CSR_MSTATUS       = 12'h300;
  localparam logic [11:0] CSR_MIE           = 12'h304;
  localparam logic [11:0] CSR_MTVEC         = 12'h305;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
  localparam logic [11:0] CSR_MEPC          = 12'h341;
  localparam logic [11:0] CSR_MCAUSE        = 12'h342;
  localparam logic [11:0] CSR_MIP           = 12'h344;

  // Machine counters (writable) and their read-only user shadows
  localparam logic [11:0] CSR_MCYCLE            = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET          = 12'hB02;
  localparam logic [11:0] CSR_MHPMCOUNTER_BASE  = 12'hB03;
  localparam logic [11:0] CSR_MCYCLEH           = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH         = 12'hB82;
  localparam logic [11:0] CSR_MHPMCOUNTERH_BASE = 12'hB83;
  localparam logic [11:0] CSR_CYCLE             = 12'hC00;
  localparam logic [11:0] CSR_INSTRET           = 12'hC02;
  localparam logic [11:0] CSR_HPMCOUNTER_BASE   = 12'hC03;
  localparam logic [11:0] CSR_CYCLEH            = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH          = 12'hC82;
  localparam logic [11:0] CSR_HPMCOUNTERH_BASE  = 12'hC83;

  localparam logic [11:0] CSR_MHARTID = 12'hF14;

  // mstatus fields
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;

  // mie / mip fields (same positions in both)
  localparam int IRQ_SW_BIT    = 3;
  localparam int IRQ_TIMER_BIT = 7;
  localparam int IRQ_EXT_BIT   = 11;

  // Counter index -> low 7 address bits (and mcountinhibit bit):
  // 0 = cycle, 1 = instret, 2+k = hpmcounter(3+k). Offset 1 (time) is skipped.
  function automatic logic [6:0] cnt_offset(input int unsigned idx);
    return (idx == 0) ? 7'd0 : 7'(idx + 1);
  endfunction

endpackage

// File: rtl/csr_counter_ext.sv
// One CounterWidth-bit performance counter with split 32-bit write ports.
// A write to either half replaces that half and suppresses the increment;
// the untouched half keeps its current value (no carry from the write).
module csr_counter_ext #(
  parameter int unsigned CounterWidth = 64
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_i,
  input  logic        inc_i,
  input  logic        we_lo_i,
  input  logic        we_hi_i,
  input  logic [31:0] wdata_lo_i,
  input  logic [31:0] wdata_hi_i,
  output logic [63:0] value_o
);

  localparam logic [CounterWidth-1:0] One = CounterWidth'(1);

  logic [CounterWidth-1:0] cnt_q, cnt_d;

  // Next count: CSR writes take priority over the increment.
  always_comb begin
    cnt_d = cnt_q;
    if (we_lo_i || we_hi_i) begin
      if (we_lo_i) cnt_d[31:0] = wdata_lo_i;
      if (we_hi_i) cnt_d[CounterWidth-1:32] = wdata_hi_i[CounterWidth-33:0];
    end else if (en_i && inc_i) begin
      cnt_d = cnt_q + One;
    end
  end

  // Counter state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  // Zero-extend to the 64-bit read view.
  always_comb begin
    value_o = '0;
    value_o[CounterWidth-1:0] = cnt_q;
  end

endmodule

// File: rtl/csr_file_ext.sv
// Machine-mode CSR file: ex-side atomic CSR ops, clint-side plain access,
// per-register arbitration (ex wins on a collision), counters and mip/mie.
module csr_file_ext
  import tinyriscv_pkg::*;
#(
  parameter int unsigned NumHpm        = 2,
  parameter int unsigned CounterWidth  = 64,
  parameter bit          MtvecVectored = 1'b1,
  parameter logic [31:0] HartId        = 32'd0
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   ex_we_i,
  input  csr_op_e                                ex_op_i,
  input  logic [11:0]                            ex_addr_i,
  input  logic [31:0]                            ex_wdata_i,
  output logic [31:0]                            ex_rdata_o,
  output logic                                   ex_illegal_o,
  input  logic                                   clint_we_i,
  input  logic [11:0]                            clint_waddr_i,
  input  logic [11:0]                            clint_raddr_i,
  input  logic [31:0]                            clint_wdata_i,
  output logic [31:0]                            clint_rdata_o,
  input  logic                                   instret_i,
  input  logic [(NumHpm > 0 ? NumHpm : 1)-1:0]   hpm_event_i,
  input  logic                                   irq_sw_i,
  input  logic                                   irq_timer_i,
  input  logic                                   irq_ext_i,
  output logic                                   global_int_en_o,
  output logic                                   irq_pending_o,
  output logic [31:0]                            mtvec_o,
  output logic [31:0]                            mepc_o,
  output logic [31:0]                            mstatus_o
);

  localparam int unsigned NumCnt      = 2 + NumHpm;
  localparam logic [31:0] MieMask     = 32'h0000_0888;
  localparam logic [31:0] MepcMask    = 32'hFFFF_FFFC;
  localparam logic [31:0] MtvecMask   = MtvecVectored ? 32'hFFFF_FFFD : 32'hFFFF_FFFC;
  localparam logic [31:0] InhibitMask = 32'h5 | (((32'd1 << NumHpm) - 32'd1) << 3);

  // Architectural state
  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic [31:0] mie_q, mie_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] minhibit_q, minhibit_d;
  logic [2:0]  irq_q, irq_d;  // {ext, timer, sw}

  // Read views
  logic [31:0] mstatus_val;
  logic [31:0] mip_val;
  logic [63:0] cnt_val [NumCnt];

  // Ex-side decode and op result
  logic [32:0] ex_rd;
  logic        ex_wr;
  logic [31:0] ex_new;
  logic [32:0] clint_rd;

  // Per-register write arbitration temporaries
  logic [32:0] w_mstatus, w_mie, w_mtvec, w_mscratch, w_mepc, w_mcause, w_minhibit;

  // {implemented, value} for any CSR address.
  function automatic logic [32:0] csr_read(input logic [11:0] a);
    logic [32:0] r;
    r = '0;
    case (a)
      CSR_MSTATUS:       r = {1'b1, mstatus_val};
      CSR_MIE:           r = {1'b1, mie_q};
      CSR_MTVEC:         r = {1'b1, mtvec_q};
      CSR_MCOUNTINHIBIT: r = {1'b1, minhibit_q};
      CSR_MSCRATCH:      r = {1'b1, mscratch_q};
      CSR_MEPC:          r = {1'b1, mepc_q};
      CSR_MCAUSE:        r = {1'b1, mcause_q};
      CSR_MIP:           r = {1'b1, mip_val};
      CSR_MHARTID:       r = {1'b1, HartId};
      default: begin
        if (a[11:8] == 4'hB || a[11:8] == 4'hC) begin
          for (int unsigned c = 0; c < NumCnt; c++) begin
            if (a[6:0] == cnt_offset(c)) begin
              r = {1'b1, a[7] ? cnt_val[c][63:32] : cnt_val[c][31:0]};
            end
          end
        end
      end
    endcase
    return r;
  endfunction

  // {write enable, raw data} for register address a; ex has priority.
  function automatic logic [32:0] wr_sel(input logic [11:0] a);
    if (ex_wr && ex_addr_i == a)              return {1'b1, ex_new};
    else if (clint_we_i && clint_waddr_i == a) return {1'b1, clint_wdata_i};
    else                                       return '0;
  endfunction

  // Assemble composite read views.
  always_comb begin
    mstatus_val = 32'h0000_1800;
    mstatus_val[MSTATUS_MIE_BIT]  = mstatus_mie_q;
    mstatus_val[MSTATUS_MPIE_BIT] = mstatus_mpie_q;
    mip_val = '0;
    mip_val[IRQ_SW_BIT]    = irq_q[0];
    mip_val[IRQ_TIMER_BIT] = irq_q[1];
    mip_val[IRQ_EXT_BIT]   = irq_q[2];
  end

  // Ex port: combinational read, legality check and atomic op result.
  always_comb begin
    ex_rd        = csr_read(ex_addr_i);
    ex_illegal_o = ~ex_rd[32] | (ex_we_i & (ex_addr_i[11:10] == 2'b11));
    ex_rdata_o   = ex_illegal_o ? 32'd0 : ex_rd[31:0];
    ex_wr        = ex_we_i & ~ex_illegal_o;
    case (ex_op_i)
      CSR_OP_SET:   ex_new = ex_rd[31:0] | ex_wdata_i;
      CSR_OP_CLEAR: ex_new = ex_rd[31:0] & ~ex_wdata_i;
      default:      ex_new = ex_wdata_i;
    endcase
  end

  // Clint port read with same-cycle write bypass.
  always_comb begin
    clint_rd = csr_read(clint_raddr_i);
    if (clint_we_i && clint_waddr_i == clint_raddr_i) clint_rdata_o = clint_wdata_i;
    else                                             clint_rdata_o = clint_rd[31:0];
  end

  // Next-state for the plain registers, with field masks applied on write.
  always_comb begin
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_d          = mie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    minhibit_d     = minhibit_q;
    irq_d          = {irq_ext_i, irq_timer_i, irq_sw_i};

    w_mstatus  = wr_sel(CSR_MSTATUS);
    w_mie      = wr_sel(CSR_MIE);
    w_mtvec    = wr_sel(CSR_MTVEC);
    w_mscratch = wr_sel(CSR_MSCRATCH);
    w_mepc     = wr_sel(CSR_MEPC);
    w_mcause   = wr_sel(CSR_MCAUSE);
    w_minhibit = wr_sel(CSR_MCOUNTINHIBIT);

    if (w_mstatus[32]) begin
      mstatus_mie_d  = w_mstatus[MSTATUS_MIE_BIT];
      mstatus_mpie_d = w_mstatus[MSTATUS_MPIE_BIT];
    end
    if (w_mie[32])      mie_d      = w_mie[31:0] & MieMask;
    if (w_mtvec[32])    mtvec_d    = w_mtvec[31:0] & MtvecMask;
    if (w_mscratch[32]) mscratch_d = w_mscratch[31:0];
    if (w_mepc[32])     mepc_d     = w_mepc[31:0] & MepcMask;
    if (w_mcause[32])   mcause_d   = w_mcause[31:0];
    if (w_minhibit[32]) minhibit_d = w_minhibit[31:0] & InhibitMask;
  end

  // CSR and interrupt-sample registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_q          <= '0;
      mtvec_q        <= '0;
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      minhibit_q     <= '0;
      irq_q          <= '0;
    end else begin
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_q          <= mie_d;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      minhibit_q     <= minhibit_d;
      irq_q          <= irq_d;
    end
  end

  // Counter bank: cycle, instret, then hpm counters.
  for (genvar c = 0; c < NumCnt; c++) begin : g_cnt
    localparam logic [6:0]  Off    = cnt_offset(c);
    localparam int          OffI   = int'(Off);
    localparam logic [11:0] LoAddr = {4'hB, 1'b0, Off};
    localparam logic [11:0] HiAddr = {4'hB, 1'b1, Off};

    logic [32:0] wlo, whi;
    logic        inc;

    // Arbitrated write requests for each counter half.
    always_comb begin
      wlo = wr_sel(LoAddr);
      whi = wr_sel(HiAddr);
    end

    if (c == 0) begin : g_cycle
      assign inc = 1'b1;
    end else if (c == 1) begin : g_instret
      assign inc = instret_i;
    end else begin : g_hpm
      assign inc = hpm_event_i[c-2];
    end

    csr_counter_ext #(
      .CounterWidth(CounterWidth)
    ) u_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .en_i       (~minhibit_q[OffI]),
      .inc_i      (inc),
      .we_lo_i    (wlo[32]),
      .we_hi_i    (whi[32]),
      .wdata_lo_i (wlo[31:0]),
      .wdata_hi_i (whi[31:0]),
      .value_o    (cnt_val[c])
    );
  end

  assign global_int_en_o = mstatus_mie_q;
  assign irq_pending_o   = mstatus_mie_q & (|(mip_val & mie_q));
  assign mtvec_o         = mtvec_q;
  assign mepc_o          = mepc_q;
  assign mstatus_o       = mstatus_val;

endmodule

// File: tb/tb_csr_file_ext.sv
// Directed bench for csr_file_ext with hand-computed expectations.
module tb_csr_file_ext;
  import tinyriscv_pkg::*;

  localparam logic [31:0] HART = 32'hCAFE_0001;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        ex_we;
  csr_op_e     ex_op;
  logic [11:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [31:0] ex_rdata;
  logic        ex_illegal;
  logic        clint_we;
  logic [11:0] clint_waddr, clint_raddr;
  logic [31:0] clint_wdata, clint_rdata;
  logic        instret;
  logic [1:0]  hpm_event;
  logic        irq_sw, irq_timer, irq_ext;
  logic        gie, pending;
  logic [31:0] mtvec, mepc, mstatus;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  csr_file_ext #(
    .NumHpm(2), .CounterWidth(64), .MtvecVectored(1'b1), .HartId(HART)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .ex_we_i(ex_we), .ex_op_i(ex_op), .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata),
    .ex_rdata_o(ex_rdata), .ex_illegal_o(ex_illegal),
    .clint_we_i(clint_we), .clint_waddr_i(clint_waddr), .clint_raddr_i(clint_raddr),
    .clint_wdata_i(clint_wdata), .clint_rdata_o(clint_rdata),
    .instret_i(instret), .hpm_event_i(hpm_event),
    .irq_sw_i(irq_sw), .irq_timer_i(irq_timer), .irq_ext_i(irq_ext),
    .global_int_en_o(gie), .irq_pending_o(pending),
    .mtvec_o(mtvec), .mepc_o(mepc), .mstatus_o(mstatus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ex_write(input logic [11:0] a, input csr_op_e op, input logic [31:0] d);
    ex_we = 1'b1; ex_addr = a; ex_op = op; ex_wdata = d;
  endtask

  task automatic clint_write(input logic [11:0] a, input logic [31:0] d);
    clint_we = 1'b1; clint_waddr = a; clint_wdata = d;
  endtask

  task automatic idle();
    ex_we = 1'b0; clint_we = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0; ex_we = 1'b0; ex_op = CSR_OP_WRITE; ex_addr = CSR_MSTATUS; ex_wdata = '0;
    clint_we = 1'b0; clint_waddr = CSR_MSCRATCH; clint_raddr = CSR_MSCRATCH; clint_wdata = '0;
    instret = 1'b0; hpm_event = '0; irq_sw = 1'b0; irq_timer = 1'b0; irq_ext = 1'b0;

    // Reset values
    #12;
    chk("rst_mstatus", mstatus, 32'h1800);
    chk("rst_mtvec", mtvec, 32'h0);
    chk("rst_mepc", mepc, 32'h0);
    chk("rst_gie", gie, 32'h0);
    chk("rst_pending", pending, 32'h0);
    chk("rst_illegal", ex_illegal, 32'h0);
    chk("rst_rd_mstatus", ex_rdata, 32'h1800);
    rst_ni = 1'b1;
    step();
    ex_addr = CSR_MCYCLE; #1;
    chk("mcycle_first", ex_rdata, 32'h1);

    // Load state, ex and clint on different registers in one cycle
    ex_write(CSR_MEPC, CSR_OP_WRITE, 32'h45);
    clint_write(CSR_MTVEC, 32'h103);
    step(); idle();
    chk("mepc_masked", mepc, 32'h44);
    chk("mtvec_masked", mtvec, 32'h101);
    ex_write(CSR_MSTATUS, CSR_OP_WRITE, 32'h88);
    step(); idle();
    chk("mstatus_wr", mstatus, 32'h1888);
    chk("gie_set", gie, 32'h1);
    ex_write(CSR_MCYCLE, CSR_OP_WRITE, 32'h1234);
    step(); idle();
    ex_addr = CSR_MCYCLE; #1;
    chk("mcycle_1234", ex_rdata, 32'h1234);

    // Asynchronous reset mid-count
    rst_ni = 1'b0; #1;
    chk("arst_mstatus", mstatus, 32'h1800);
    chk("arst_mepc", mepc, 32'h0);
    chk("arst_mtvec", mtvec, 32'h0);
    chk("arst_gie", gie, 32'h0);
    chk("arst_mcycle", ex_rdata, 32'h0);
    step();
    rst_ni = 1'b1;
    step();
    chk("mcycle_restart1", ex_rdata, 32'h1);
    step();
    chk("mcycle_restart2", ex_rdata, 32'h2);

    // CSRRS then CSRRC on mstatus
    ex_write(CSR_MSTATUS, CSR_OP_SET, 32'h8); #1;
    chk("csrrs_old", ex_rdata, 32'h1800);
    chk("csrrs_gie_before", gie, 32'h0);
    step();
    ex_write(CSR_MSTATUS, CSR_OP_CLEAR, 32'h8); #1;
    chk("csrrc_old", ex_rdata, 32'h1808);
    chk("csrrc_gie_before", gie, 32'h1);
    step(); idle(); #1;
    chk("csrrc_gie_after", gie, 32'h0);
    chk("csrrc_rd", ex_rdata, 32'h1800);

    // Illegal accesses
    ex_write(CSR_MCYCLE, CSR_OP_WRITE, 32'h100);
    step();
    ex_write(CSR_CYCLE, CSR_OP_WRITE, 32'h55); #1;
    chk("ill_c00", ex_illegal, 32'h1);
    chk("ill_c00_rd", ex_rdata, 32'h0);
    step();
    ex_write(12'hFFF, CSR_OP_WRITE, 32'h55); #1;
    chk("ill_fff", ex_illegal, 32'h1);
    step();
    ex_write(CSR_MHARTID, CSR_OP_WRITE, 32'h0); #1;
    chk("ill_f14_wr", ex_illegal, 32'h1);
    chk("ill_f14_rd", ex_rdata, 32'h0);
    step(); idle();
    ex_addr = CSR_MHARTID; #1;
    chk("hartid_legal", ex_illegal, 32'h0);
    chk("hartid_val", ex_rdata, HART);
    ex_addr = 12'hFFF; #1;
    chk("ill_fff_rd", ex_illegal, 32'h1);
    ex_addr = CSR_CYCLE; #1;
    chk("cycle_unchanged", ex_rdata, 32'h103);

    // Interrupts
    ex_write(CSR_MIE, CSR_OP_WRITE, 32'hFFFF_FFFF);
    step(); idle();
    ex_addr = CSR_MIE; #1;
    chk("mie_mask", ex_rdata, 32'h888);
    ex_write(CSR_MIE, CSR_OP_WRITE, 32'h80);
    step();
    ex_write(CSR_MSTATUS, CSR_OP_SET, 32'h8);
    step(); idle(); #1;
    chk("irq_gie", gie, 32'h1);
    chk("irq_none", pending, 32'h0);
    irq_sw = 1'b1;
    step();
    ex_addr = CSR_MIP; #1;
    chk("mip_sw", ex_rdata, 32'h8);
    chk("sw_masked", pending, 32'h0);
    irq_sw = 1'b0; irq_timer = 1'b1; #1;
    chk("timer_lat", pending, 32'h0);
    step();
    chk("mip_timer", ex_rdata, 32'h80);
    chk("timer_pend", pending, 32'h1);
    irq_timer = 1'b0; #1;
    chk("timer_hold", pending, 32'h1);
    step();
    chk("timer_clr", pending, 32'h0);
    chk("mip_clr", ex_rdata, 32'h0);

    // Counter wrap across halves
    ex_write(CSR_MCYCLEH, CSR_OP_WRITE, 32'h0);
    clint_write(CSR_MCYCLE, 32'hFFFF_FFFF);
    step(); idle();
    ex_addr = CSR_MCYCLE; clint_raddr = CSR_MCYCLEH; #1;
    chk("wrap_lo_pre", ex_rdata, 32'hFFFF_FFFF);
    chk("wrap_hi_pre", clint_rdata, 32'h0);
    step();
    chk("wrap_lo", ex_rdata, 32'h0);
    chk("wrap_hi", clint_rdata, 32'h1);
    clint_raddr = CSR_CYCLEH; #1;
    chk("wrap_shadow_hi", clint_rdata, 32'h1);
    ex_write(CSR_MCYCLE, CSR_OP_WRITE, 32'h5);
    step(); idle(); #1;
    chk("mcycle_wr5", ex_rdata, 32'h5);
    chk("mcycleh_nocarry", clint_rdata, 32'h1);
    step();
    chk("mcycle_6", ex_rdata, 32'h6);

    // instret / hpm counters and inhibit
    instret = 1'b1; hpm_event = 2'b10;
    step();
    hpm_event = 2'b00;
    step();
    instret = 1'b0;
    ex_addr = CSR_MINSTRET; clint_raddr = 12'hB04; #1;
    chk("minstret_2", ex_rdata, 32'h2);
    chk("hpm4_1", clint_rdata, 32'h1);
    clint_raddr = CSR_MHPMCOUNTER_BASE; #1;
    chk("hpm3_0", clint_rdata, 32'h0);
    ex_write(CSR_MCOUNTINHIBIT, CSR_OP_WRITE, 32'hFFFF_FFFF);
    step(); idle();
    ex_addr = CSR_MCOUNTINHIBIT; #1;
    chk("inhibit_mask", ex_rdata, 32'h1D);
    ex_addr = CSR_MCYCLE; instret = 1'b1; #1;
    chk("mcycle_9", ex_rdata, 32'h9);
    step();
    instret = 1'b0;
    chk("mcycle_held", ex_rdata, 32'h9);
    ex_addr = CSR_MINSTRET; #1;
    chk("minstret_held", ex_rdata, 32'h2);

    // Same-cycle arbitration
    ex_write(CSR_MSCRATCH, CSR_OP_WRITE, 32'hA);
    clint_write(CSR_MEPC, 32'h103);
    step(); idle();
    ex_addr = CSR_MSCRATCH; #1;
    chk("arb_mepc", mepc, 32'h100);
    chk("arb_mscratch", ex_rdata, 32'hA);
    ex_write(CSR_MEPC, CSR_OP_WRITE, 32'h200);
    clint_write(CSR_MEPC, 32'h300);
    clint_raddr = CSR_MEPC; #1;
    chk("clint_bypass", clint_rdata, 32'h300);
    step(); idle(); #1;
    chk("arb_ex_wins", mepc, 32'h200);
    chk("clint_rd_mepc", clint_rdata, 32'h200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
